// File: rtl/led_pattern_pynq_if.sv
// led_pattern_pynq_if: control registers and LED-side outputs of the pattern generator
interface led_pattern_pynq_if #(
  parameter int N_LED  = 4,
  parameter int CDIV_W = 32
);
  localparam int PW = $clog2(2*N_LED);
  logic [CDIV_W-1:0] CDIV;
  logic [1:0]        MODE;
  logic              RUN;
  logic              STEP;
  logic [N_LED-1:0]  LED;
  logic [PW-1:0]     POS;
  logic              TICK;
  modport master (output CDIV, MODE, RUN, STEP, input LED, POS, TICK);
  modport slave  (input CDIV, MODE, RUN, STEP, output LED, POS, TICK);
endinterface

// File: rtl/led_pattern_pynq.sv
// led_pattern_pynq: prescaled bounce/rotate/bar LED pattern generator with freeze and single-step
module led_pattern_pynq #(
  parameter int N_LED  = 4,
  parameter int CDIV_W = 32
) (
  input logic CLK,
  input logic RESET,
  led_pattern_pynq_if.slave bus
);
  localparam int PW = $clog2(2*N_LED);
  localparam int TW = PW + 1;
  logic [CDIV_W-1:0] count_q, count_d;
  logic [PW-1:0]     pos_q, pos_d, last;
  logic [1:0]        mode_q, mode_d;
  logic              tick_q, tick_d;
  logic              adv, mode_chg;
  logic [TW-1:0]     tgt;
  logic [N_LED-1:0]  led;
  // state registers; reset wins over everything
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      pos_q   <= '0;
      mode_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end
  // next state: a mode change restarts the pattern and swallows any same-cycle advance
  always_comb begin
    mode_chg = bus.MODE != mode_q;
    adv      = bus.RUN ? (count_q >= bus.CDIV) : bus.STEP;
    last     = mode_q == 2'd0 ? PW'(2*N_LED-3) : PW'(N_LED-1);
    count_d  = mode_chg ? '0 : !bus.RUN ? count_q : count_q >= bus.CDIV ? '0 : count_q + CDIV_W'(1);
    pos_d    = mode_chg ? '0 : !adv ? pos_q : pos_q == last ? '0 : pos_q + PW'(1);
    mode_d   = bus.MODE;
    tick_d   = !mode_chg && adv;
  end
  // LED decode: index of the single lit bit, or a thermometer fill for BAR
  always_comb begin
    tgt = mode_q == 2'd0 ? (pos_q < PW'(N_LED) ? {1'b0, pos_q} : TW'(2*N_LED-2) - {1'b0, pos_q}) :
          mode_q == 2'd1 ? {1'b0, pos_q} : TW'(N_LED-1) - {1'b0, pos_q};
    led = '0;
    for (int i = 0; i < N_LED; i++)
      led[i] = mode_q == 2'd3 ? (i <= int'(pos_q)) : (i == int'(tgt));
  end
  assign bus.LED  = led;
  assign bus.POS  = pos_q;
  assign bus.TICK = tick_q;
endmodule

// File: doc/led_pattern_pynq.md
# led_pattern_pynq

Parametrised LED pattern generator for the PYNQ LED bank, the successor of the 4-LED bouncing-light block. It drives `N_LED` outputs from a programmable prescaler and supports four patterns: bounce, rotate left, rotate right and bar fill. It also adds run/freeze with single-step, an advance strobe and a position output for the PS-side driver. It sits directly between the AXI-GPIO control registers (`CDIV`, `MODE`, `RUN`, `STEP`) and the board LED pins.

## Interface
- `N_LED`, 4, number of LEDs; legal range ≥ 2.
- `CDIV_W`, 32, width of the prescaler divisor and counter.
- `PW`, `$clog2(2*N_LED)`, width of `POS`. Localparam, not overridable.
- `CLK` input 1: the single clock.
- `RESET` input 1: synchronous, active-high reset.
- `CDIV` input `CDIV_W`: prescaler divisor; one advance every `CDIV+1` cycles.
- `MODE` input 2: pattern select. 0 = BOUNCE, 1 = ROTL, 2 = ROTR, 3 = BAR.
- `RUN` input 1: 1 = free-running; 0 = frozen.
- `STEP` input 1: manual advance, honoured only while `RUN=0`.
- `LED` output `N_LED`: pattern output, decoded from `pos` and `mode_q`.
- `POS` output `PW`: current pattern position `pos`.
- `TICK` output 1: registered one-cycle strobe, high in the first cycle `LED` shows a newly advanced pattern.

## Operation
- **State registers:**
  - `count[CDIV_W-1:0]`
  - `pos[PW-1:0]`
  - `mode_q[1:0]`
  - `TICK`
- **Advance condition `adv`:** `(RUN && count >= CDIV) || (!RUN && STEP)`.
- **Prescaler:**
  - `RUN=1`: if `count >= CDIV`, `count <= 0`; else `count <= count + 1`.
  - `RUN=0`: `count` holds.
  - `CDIV=0` gives an advance every cycle.
  - Lowering `CDIV` below `count` gives an advance on the next cycle (comparison is `>=`).
- **Position wrap (`last`):**
  - BOUNCE: `last = 2*N_LED-3`.
  - ROTL, ROTR, BAR: `last = N_LED-1`.
  - On `adv`: `pos <= (pos == last) ? 0 : pos + 1`.
- **LED decode (pure function of `mode_q` and `pos`):**
  - BOUNCE: for `pos < N_LED`, bit `pos` is lit; otherwise bit `2*N_LED-2-pos` is lit. With `N_LED=4`: 0001, 0010, 0100, 1000, 0100, 0010.
  - ROTL: bit `pos` lit.
  - ROTR: bit `N_LED-1-pos` lit.
  - BAR: bits `[pos:0]` lit.
  - Exactly one bit is lit in every mode except BAR.
- **Mode change:**
  - Triggered when `MODE != mode_q`.
  - At the next edge: `mode_q <= MODE`, `pos <= 0`, `count <= 0`, `TICK <= 0`.
  - Applies regardless of `RUN`.
  - Takes priority over `adv` in the same cycle; the advance is dropped.
- **Step:**
  - Level-sampled every cycle while `RUN=0`: each cycle with `STEP=1` produces one advance.
  - The PS issues single-cycle pulses.
  - `STEP` is ignored while `RUN=1`.
- **`TICK`:** `TICK <= adv` (when there is no mode change), so it aligns with the updated `pos`.

## Timing
- **Reset** (`RESET=1` at an edge, including mid-operation; highest priority): `count=0`, `pos=0`, `mode_q=0`, `TICK=0`. Outputs after reset: `LED` = bit 0 only, `POS=0`, `TICK=0`.
- **First advance:** after `RESET` deasserts with `RUN=1`, `TICK` is first high `CDIV+1` cycles after the first non-reset edge; thereafter every `CDIV+1` cycles.
- **LED/POS latency:** combinational from registers; they change on the edge where `adv` is sampled, the same edge that sets `TICK`.
- **MODE latency:** a `MODE` change is visible on `LED` one cycle later, starting at `pos=0`. The first advance in the new mode comes `CDIV+1` cycles after that edge.
- **RUN transitions:** 1→0 freezes `count` and `pos` on the next edge. 0→1 resumes from the held `count`; there is no restart.
- **Step latency:** a `STEP` pulse with `RUN=0` updates `LED` and raises `TICK` at the following edge.

## Test plan
- **Bounce, default width:** `N_LED=4`, `CDIV=3`, `MODE=0`, `RUN=1`, release `RESET` → `LED` = 0001 for 4 cycles, then 0010, 0100, 1000, 0100, 0010, 0001. `TICK` is high for exactly one cycle every 4 cycles; `POS` steps 0..5 and wraps.
- **Maximum rate, ROTR:** `CDIV=0`, `MODE=2` → `LED` advances every cycle: 1000, 0100, 0010, 0001, 1000. `TICK` is held high continuously.
- **Mid-run mode switch:** during ROTL with `POS=2`, set `MODE=3` → next cycle `LED=0001`, `POS=0`, `TICK=0`. After `CDIV+1` cycles `LED=0011`, then 0111, 1111, 0001.
- **Freeze and single-step:** `RUN=0` → `LED` holds for 100 cycles. Three isolated 1-cycle `STEP` pulses → three advances with three `TICK` strobes. `STEP` with `RUN=1` → no extra advance.
- **Wider bank:** `N_LED=8`, `MODE=0`, `CDIV=1` → bounce period of 14 advances. Turnaround is 10000000 → 01000000, and 00000010 → 00000001 → 00000010.
- **Reset mid-operation:** assert `RESET` for 1 cycle at `POS=4`, `MODE=1` → `LED=0001`, `POS=0`, `TICK=0`, `mode_q` = BOUNCE. The first `TICK` comes `CDIV+1` cycles after release, if `MODE` is held at 0.
